// File: rtl/junction_controller.sv
// junction_controller: demand-actuated sequencer for a two-road junction.
// Rests on green for the last-served road, yields on opposing vehicle or
// pedestrian demand, and inserts an all-red walk phase when requested.
// Lamp encoding per road is {red, amber, green}.
module junction_controller #(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 10,
   parameter int AMBER     = 2,
   parameter int REDAMBER  = 1,
   parameter int ALLRED    = 1,
   parameter int WALK      = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       reqA,
   input  logic       reqB,
   input  logic       ped_req,
   output logic [2:0] lightsA,
   output logic [2:0] lightsB,
   output logic       ped_walk,
   output logic       ped_wait
);

   function automatic int pmax6(input int a, input int b, input int c,
                                input int d, input int e, input int f);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      if (f > m) m = f;
      return m;
   endfunction

   localparam int PMAX = pmax6(MIN_GREEN, MAX_GREEN, AMBER, REDAMBER, ALLRED, WALK);
   localparam int CW   = $clog2(PMAX) + 1;

   localparam logic [CW-1:0] CNT_SAT   = CW'(PMAX - 1);
   localparam logic [CW-1:0] MING_M1   = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] MAXG_M1   = CW'(MAX_GREEN - 1);
   localparam logic [CW-1:0] AMBER_M1  = CW'(AMBER - 1);
   localparam logic [CW-1:0] RA_M1     = CW'(REDAMBER - 1);
   localparam logic [CW-1:0] ALLRED_M1 = CW'(ALLRED - 1);
   localparam logic [CW-1:0] WALK_M1   = CW'(WALK - 1);

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_RA  = 3'b110;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_AMB = 3'b010;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_RA_A,
      ST_GREEN_A,
      ST_AMBER_A,
      ST_RA_B,
      ST_GREEN_B,
      ST_AMBER_B,
      ST_WALK
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic          next_dir;   // 0 = road A, 1 = road B
   logic          dmdA, dmdB, ped_pend;
   logic          dmdA_n, dmdB_n, ped_pend_n;
   logic          min_ok, max_ok;

   // Phase counter holds at its ceiling so long rests never wrap.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   function automatic logic [2:0] lamp_a(input state_t s);
      case (s)
         ST_RA_A:    return L_RA;
         ST_GREEN_A: return L_GRN;
         ST_AMBER_A: return L_AMB;
         default:    return L_RED;
      endcase
   endfunction

   function automatic logic [2:0] lamp_b(input state_t s);
      case (s)
         ST_RA_B:    return L_RA;
         ST_GREEN_B: return L_GRN;
         ST_AMBER_B: return L_AMB;
         default:    return L_RED;
      endcase
   endfunction

   // Next-state decode and demand latch updates; entry into a serving
   // state clears its demand and takes priority over a same-cycle request.
   always_comb begin
      state_n = state;
      min_ok  = (cnt >= MING_M1);
      max_ok  = (cnt >= MAXG_M1);
      case (state)
         ST_CLEAR:
            if (cnt == ALLRED_M1)
               state_n = ped_pend ? ST_WALK : (next_dir ? ST_RA_B : ST_RA_A);
         ST_WALK:
            if (cnt == WALK_M1)
               state_n = next_dir ? ST_RA_B : ST_RA_A;
         ST_RA_A:
            if (cnt == RA_M1) state_n = ST_GREEN_A;
         ST_RA_B:
            if (cnt == RA_M1) state_n = ST_GREEN_B;
         ST_GREEN_A:
            if (min_ok && (dmdB || ped_pend) && (!reqA || max_ok))
               state_n = ST_AMBER_A;
         ST_GREEN_B:
            if (min_ok && (dmdA || ped_pend) && (!reqB || max_ok))
               state_n = ST_AMBER_B;
         ST_AMBER_A:
            if (cnt == AMBER_M1) state_n = ST_CLEAR;
         ST_AMBER_B:
            if (cnt == AMBER_M1) state_n = ST_CLEAR;
         default:
            state_n = ST_CLEAR;
      endcase

      dmdA_n = dmdA | (reqA && (state != ST_GREEN_A));
      if (state_n == ST_GREEN_A && state != ST_GREEN_A) dmdA_n = 1'b0;

      dmdB_n = dmdB | (reqB && (state != ST_GREEN_B));
      if (state_n == ST_GREEN_B && state != ST_GREEN_B) dmdB_n = 1'b0;

      ped_pend_n = ped_pend | (ped_req && (state != ST_WALK));
      if (state_n == ST_WALK && state != ST_WALK) ped_pend_n = 1'b0;
   end

   // State, counter, demand latches and lamp outputs registered together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         cnt      <= '0;
         next_dir <= 1'b0;
         dmdA     <= 1'b0;
         dmdB     <= 1'b0;
         ped_pend <= 1'b0;
         lightsA  <= L_RED;
         lightsB  <= L_RED;
         ped_walk <= 1'b0;
         ped_wait <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= (state_n != state) ? '0 : sat_inc(cnt);
         if (state == ST_AMBER_A && state_n == ST_CLEAR) next_dir <= 1'b1;
         if (state == ST_AMBER_B && state_n == ST_CLEAR) next_dir <= 1'b0;
         dmdA     <= dmdA_n;
         dmdB     <= dmdB_n;
         ped_pend <= ped_pend_n;
         lightsA  <= lamp_a(state_n);
         lightsB  <= lamp_b(state_n);
         ped_walk <= (state_n == ST_WALK);
         ped_wait <= ped_pend_n;
      end
   end

endmodule
